// File: rtl/fp_subtractor_seq.sv
// Multi-cycle floating-point subtractor (x = a - b) with valid/ready handshakes on both sides.
// Alignment and normalization shift one bit per cycle, and every step truncates.
module fp_subtractor_seq #(
  parameter int W_MANTISSA = 8,
  parameter int W_EXPONENT = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [W_MANTISSA+W_EXPONENT:0]         in_a,
  input  logic [W_MANTISSA+W_EXPONENT:0]         in_b,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [W_MANTISSA+W_EXPONENT:0]         out_x,
  output logic                                   overflow,
  output logic                                   underflow,
  output logic                                   exception
);

  localparam int W_FP_NUMBER = W_MANTISSA + W_EXPONENT + 1;
  localparam int W_SIG       = W_MANTISSA + 1;
  localparam int W_SUM       = W_MANTISSA + 2;
  localparam int W_EXP1      = W_EXPONENT + 1;

  localparam logic [W_EXPONENT-1:0]  EXP_ONE  = {{(W_EXPONENT-1){1'b0}}, 1'b1};
  localparam logic [W_EXP1-1:0]      EXP1_ONE = {{W_EXPONENT{1'b0}}, 1'b1};
  localparam logic [W_EXP1-1:0]      EXP1_MAX = {1'b0, {W_EXPONENT{1'b1}}};
  localparam logic [W_FP_NUMBER-1:0] EXC_NAN  =
    {1'b0, {W_EXPONENT{1'b1}}, 1'b1, {(W_MANTISSA-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_SUB   = 3'd2,
    S_NORM  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [W_EXPONENT-1:0] exp_of(input logic [W_FP_NUMBER-1:0] v);
    exp_of = v[W_MANTISSA +: W_EXPONENT];
  endfunction

  // A zero exponent encodes zero, so the hidden bit is only present otherwise.
  function automatic logic [W_SIG-1:0] sig_of(input logic [W_FP_NUMBER-1:0] v);
    if (v[W_MANTISSA +: W_EXPONENT] == {W_EXPONENT{1'b0}}) begin
      sig_of = {W_SIG{1'b0}};
    end else begin
      sig_of = {1'b1, v[W_MANTISSA-1:0]};
    end
  endfunction

  state_t                  r_state;
  state_t                  w_state_next;
  logic [W_FP_NUMBER-1:0]  r_a;
  logic [W_FP_NUMBER-1:0]  r_b;
  logic                    r_first;
  logic                    r_l_sign;
  logic                    r_s_sign;
  logic [W_EXPONENT-1:0]   r_l_exp;
  logic [W_EXPONENT-1:0]   r_s_exp;
  logic [W_SIG-1:0]        r_l_sig;
  logic [W_SIG-1:0]        r_s_sig;
  logic                    r_res_sign;
  logic [W_EXP1-1:0]       r_res_exp;
  logic [W_SUM-1:0]        r_res_sig;
  logic [W_FP_NUMBER-1:0]  r_out_x;
  logic                    r_out_valid;
  logic                    r_overflow;
  logic                    r_underflow;
  logic                    r_exception;

  logic [W_EXPONENT-1:0]   w_a_exp;
  logic [W_EXPONENT-1:0]   w_b_exp;
  logic [W_SIG-1:0]        w_a_sig;
  logic [W_SIG-1:0]        w_b_sig;
  logic                    w_a_ge_b;
  logic                    w_ord_l_sign;
  logic                    w_ord_s_sign;
  logic [W_EXPONENT-1:0]   w_ord_l_exp;
  logic [W_EXPONENT-1:0]   w_ord_s_exp;
  logic [W_SIG-1:0]        w_ord_l_sig;
  logic [W_SIG-1:0]        w_ord_s_sig;
  logic                    w_cur_l_sign;
  logic                    w_cur_s_sign;
  logic [W_EXPONENT-1:0]   w_cur_l_exp;
  logic [W_EXPONENT-1:0]   w_cur_s_exp;
  logic [W_SIG-1:0]        w_cur_l_sig;
  logic [W_SIG-1:0]        w_cur_s_sig;
  logic                    w_align_go;
  logic                    w_exc;
  logic [W_SUM-1:0]        w_sum;
  logic [W_EXP1-1:0]       w_exp_inc;
  logic [W_EXP1-1:0]       w_exp_dec;
  logic                    w_load_out;
  logic [W_FP_NUMBER-1:0]  w_nx_x;
  logic                    w_nx_ovf;
  logic                    w_nx_unf;
  logic                    w_nx_exc;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign out_x     = r_out_x;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign exception = r_exception;

  // Operand ordering on the first ALIGN cycle; later cycles reuse the registered L/S.
  always_comb begin
    w_a_exp  = exp_of(r_a);
    w_b_exp  = exp_of(r_b);
    w_a_sig  = sig_of(r_a);
    w_b_sig  = sig_of(r_b);
    w_exc    = (w_a_exp == {W_EXPONENT{1'b1}}) || (w_b_exp == {W_EXPONENT{1'b1}});
    w_a_ge_b = (w_a_exp > w_b_exp) || ((w_a_exp == w_b_exp) && (w_a_sig >= w_b_sig));
    if (w_a_ge_b) begin
      w_ord_l_sign = r_a[W_FP_NUMBER-1];
      w_ord_l_exp  = w_a_exp;
      w_ord_l_sig  = w_a_sig;
      w_ord_s_sign = r_b[W_FP_NUMBER-1];
      w_ord_s_exp  = w_b_exp;
      w_ord_s_sig  = w_b_sig;
    end else begin
      w_ord_l_sign = r_b[W_FP_NUMBER-1];
      w_ord_l_exp  = w_b_exp;
      w_ord_l_sig  = w_b_sig;
      w_ord_s_sign = r_a[W_FP_NUMBER-1];
      w_ord_s_exp  = w_a_exp;
      w_ord_s_sig  = w_a_sig;
    end
    if (r_first) begin
      w_cur_l_sign = w_ord_l_sign;
      w_cur_l_exp  = w_ord_l_exp;
      w_cur_l_sig  = w_ord_l_sig;
      w_cur_s_sign = w_ord_s_sign;
      w_cur_s_exp  = w_ord_s_exp;
      w_cur_s_sig  = w_ord_s_sig;
    end else begin
      w_cur_l_sign = r_l_sign;
      w_cur_l_exp  = r_l_exp;
      w_cur_l_sig  = r_l_sig;
      w_cur_s_sign = r_s_sign;
      w_cur_s_exp  = r_s_exp;
      w_cur_s_sig  = r_s_sig;
    end
    w_align_go = (w_cur_l_exp == w_cur_s_exp) || (w_cur_s_sig == {W_SIG{1'b0}});
  end

  // Significand add/subtract and normalization exponent steps.
  always_comb begin
    if (r_l_sign == r_s_sign) begin
      w_sum = {1'b0, r_l_sig} + {1'b0, r_s_sig};
    end else begin
      w_sum = {1'b0, r_l_sig} - {1'b0, r_s_sig};
    end
    w_exp_inc = r_res_exp + EXP1_ONE;
    w_exp_dec = r_res_exp - EXP1_ONE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode plus the result/flag values to latch on entry to DONE.
  always_comb begin
    w_state_next = r_state;
    w_load_out   = 1'b0;
    w_nx_x       = {W_FP_NUMBER{1'b0}};
    w_nx_ovf     = 1'b0;
    w_nx_unf     = 1'b0;
    w_nx_exc     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_next = S_ALIGN;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_ALIGN: begin
        if (r_first && w_exc) begin
          w_state_next = S_DONE;
          w_load_out   = 1'b1;
          w_nx_x       = EXC_NAN;
          w_nx_exc     = 1'b1;
        end else if (w_align_go) begin
          w_state_next = S_SUB;
        end else begin
          w_state_next = S_ALIGN;
        end
      end
      S_SUB: begin
        w_state_next = S_NORM;
      end
      S_NORM: begin
        if (r_res_sig == {W_SUM{1'b0}}) begin
          w_state_next = S_DONE;
          w_load_out   = 1'b1;
        end else if (r_res_sig[W_SUM-1]) begin
          if (w_exp_inc >= EXP1_MAX) begin
            w_state_next = S_DONE;
            w_load_out   = 1'b1;
            w_nx_ovf     = 1'b1;
            w_nx_x       = {r_res_sign, {W_EXPONENT{1'b1}}, {W_MANTISSA{1'b0}}};
          end else begin
            w_state_next = S_NORM;
          end
        end else if (!r_res_sig[W_SUM-2]) begin
          if (w_exp_dec == {W_EXP1{1'b0}}) begin
            w_state_next = S_DONE;
            w_load_out   = 1'b1;
            w_nx_unf     = 1'b1;
          end else begin
            w_state_next = S_NORM;
          end
        end else begin
          w_state_next = S_DONE;
          w_load_out   = 1'b1;
          w_nx_x       = {r_res_sign, r_res_exp[W_EXPONENT-1:0], r_res_sig[W_MANTISSA-1:0]};
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_DONE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Datapath: capture, one-bit alignment, add/sub, one-bit normalization.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= {W_FP_NUMBER{1'b0}};
      r_b        <= {W_FP_NUMBER{1'b0}};
      r_first    <= 1'b0;
      r_l_sign   <= 1'b0;
      r_s_sign   <= 1'b0;
      r_l_exp    <= {W_EXPONENT{1'b0}};
      r_s_exp    <= {W_EXPONENT{1'b0}};
      r_l_sig    <= {W_SIG{1'b0}};
      r_s_sig    <= {W_SIG{1'b0}};
      r_res_sign <= 1'b0;
      r_res_exp  <= {W_EXP1{1'b0}};
      r_res_sig  <= {W_SUM{1'b0}};
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= in_a;
            r_b     <= {~in_b[W_FP_NUMBER-1], in_b[W_FP_NUMBER-2:0]};
            r_first <= 1'b1;
          end
        end
        S_ALIGN: begin
          r_first  <= 1'b0;
          r_l_sign <= w_cur_l_sign;
          r_l_exp  <= w_cur_l_exp;
          r_l_sig  <= w_cur_l_sig;
          r_s_sign <= w_cur_s_sign;
          if (w_align_go) begin
            r_s_exp <= w_cur_s_exp;
            r_s_sig <= w_cur_s_sig;
          end else begin
            r_s_exp <= w_cur_s_exp + EXP_ONE;
            r_s_sig <= {1'b0, w_cur_s_sig[W_SIG-1:1]};
          end
        end
        S_SUB: begin
          r_res_sign <= r_l_sign;
          r_res_exp  <= {1'b0, r_l_exp};
          r_res_sig  <= w_sum;
        end
        S_NORM: begin
          if (w_state_next == S_NORM) begin
            if (r_res_sig[W_SUM-1]) begin
              r_res_sig <= {1'b0, r_res_sig[W_SUM-1:1]};
              r_res_exp <= w_exp_inc;
            end else begin
              r_res_sig <= {r_res_sig[W_SUM-2:0], 1'b0};
              r_res_exp <= w_exp_dec;
            end
          end
        end
        default: begin
          r_first <= 1'b0;
        end
      endcase
    end
  end

  // Registered result and flags; held through DONE, flags cleared on the out handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_x     <= {W_FP_NUMBER{1'b0}};
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_exception <= 1'b0;
    end else begin
      r_out_valid <= (w_state_next == S_DONE);
      if (w_load_out) begin
        r_out_x     <= w_nx_x;
        r_overflow  <= w_nx_ovf;
        r_underflow <= w_nx_unf;
        r_exception <= w_nx_exc;
      end else if ((r_state == S_DONE) && out_ready) begin
        r_overflow  <= 1'b0;
        r_underflow <= 1'b0;
        r_exception <= 1'b0;
      end
    end
  end

endmodule
